// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage constants: ALU op classes, ALU control codes, funct codes.
// Purely declarative; no logic, no latency.
// Imported by the decoder, the execute unit and its interface users.
package mips_pkg;

  // 3-bit op class from the main control unit
  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_RTYPE = 3'b010;
  localparam logic [2:0] ALU_OP_AND   = 3'b011;
  localparam logic [2:0] ALU_OP_OR    = 3'b100;
  localparam logic [2:0] ALU_OP_SLT   = 3'b101;
  localparam logic [2:0] ALU_OP_LUI   = 3'b110;
  localparam logic [2:0] ALU_OP_ADD2  = 3'b111;

  // 4-bit ALU control codes
  localparam logic [3:0] ALU_CTRL_AND  = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR   = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SLL  = 4'b0011;
  localparam logic [3:0] ALU_CTRL_SRL  = 4'b0100;
  localparam logic [3:0] ALU_CTRL_XOR  = 4'b0101;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'b0111;
  localparam logic [3:0] ALU_CTRL_SLTU = 4'b1000;
  localparam logic [3:0] ALU_CTRL_SRA  = 4'b1001;
  localparam logic [3:0] ALU_CTRL_LUI  = 4'b1010;
  localparam logic [3:0] ALU_CTRL_NOR  = 4'b1100;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;

endpackage

// File: rtl/exec_alu_unit_if.sv
// Execute-unit bus: decode/operand inputs and registered result outputs.
// No latency of its own; carries a 1-cycle registered path.
// No backpressure: producer drives every cycle, results appear one cycle later.
// Ports: master = stage driving operands (in_valid, alu_op, funct, shamt, op_a, op_b, pc, imm_ext)
//        slave  = exec_alu_unit (returns out_valid, alu_ctrl, alu_result, alu_zero, pc_plus4, branch_target)
interface exec_alu_unit_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [2:0]   alu_op;
  logic [5:0]   funct;
  logic [4:0]   shamt;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] pc;
  logic [W-1:0] imm_ext;

  logic         out_valid;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic [W-1:0] pc_plus4;
  logic [W-1:0] branch_target;

  modport master (
    output in_valid, alu_op, funct, shamt, op_a, op_b, pc, imm_ext,
    input  out_valid, alu_ctrl, alu_result, alu_zero, pc_plus4, branch_target
  );

  modport slave (
    input  in_valid, alu_op, funct, shamt, op_a, op_b, pc, imm_ext,
    output out_valid, alu_ctrl, alu_result, alu_zero, pc_plus4, branch_target
  );
endinterface

// File: rtl/exec_alu_unit_alu_ctrl_decode.sv
// Maps control-unit op class plus funct field to the 4-bit ALU control code.
// Combinational, zero latency.
// No backpressure; pure function of its inputs.
// Ports: alu_op_i (3) op class, funct_i (6) instr[5:0], alu_ctrl_o (4) control code
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o
);

  logic [3:0] rtype_ctrl;

  always_comb begin
    rtype_ctrl = ALU_CTRL_ADD;  // unrecognised funct behaves as ADD
    case (funct_i)
      FUNCT_ADD, FUNCT_ADDU: rtype_ctrl = ALU_CTRL_ADD;
      FUNCT_SUB, FUNCT_SUBU: rtype_ctrl = ALU_CTRL_SUB;
      FUNCT_AND:             rtype_ctrl = ALU_CTRL_AND;
      FUNCT_OR:              rtype_ctrl = ALU_CTRL_OR;
      FUNCT_XOR:             rtype_ctrl = ALU_CTRL_XOR;
      FUNCT_NOR:             rtype_ctrl = ALU_CTRL_NOR;
      FUNCT_SLT:             rtype_ctrl = ALU_CTRL_SLT;
      FUNCT_SLTU:            rtype_ctrl = ALU_CTRL_SLTU;
      FUNCT_SLL:             rtype_ctrl = ALU_CTRL_SLL;
      FUNCT_SRL:             rtype_ctrl = ALU_CTRL_SRL;
      FUNCT_SRA:             rtype_ctrl = ALU_CTRL_SRA;
      default:               rtype_ctrl = ALU_CTRL_ADD;
    endcase
  end

  always_comb begin
    alu_ctrl_o = ALU_CTRL_ADD;
    case (alu_op_i)
      ALU_OP_ADD:   alu_ctrl_o = ALU_CTRL_ADD;
      ALU_OP_SUB:   alu_ctrl_o = ALU_CTRL_SUB;
      ALU_OP_RTYPE: alu_ctrl_o = rtype_ctrl;
      ALU_OP_AND:   alu_ctrl_o = ALU_CTRL_AND;
      ALU_OP_OR:    alu_ctrl_o = ALU_CTRL_OR;
      ALU_OP_SLT:   alu_ctrl_o = ALU_CTRL_SLT;
      ALU_OP_LUI:   alu_ctrl_o = ALU_CTRL_LUI;
      ALU_OP_ADD2:  alu_ctrl_o = ALU_CTRL_ADD;
      default:      alu_ctrl_o = ALU_CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/exec_alu_unit.sv
// Execute stage: ALU control decode, W-bit ALU with zero flag, PC+step and branch target.
// Latency 1 cycle: every output is registered and reloads on every clock edge.
// No backpressure or stall; out_valid simply tracks in_valid one cycle later.
// Ports: clk, rst_n (async active-low), bus (exec_alu_unit_if.slave) carrying operands in and results out
module exec_alu_unit
  import mips_pkg::*;
#(
  parameter int W       = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  exec_alu_unit_if.slave  bus
);

  logic [3:0]   alu_ctrl_d;
  logic [W-1:0] alu_result_d;
  logic         alu_zero_d;
  logic [W-1:0] pc_plus4_d;
  logic [W-1:0] branch_target_d;

  logic         out_valid_q;
  logic [3:0]   alu_ctrl_q;
  logic [W-1:0] alu_result_q;
  logic         alu_zero_q;
  logic [W-1:0] pc_plus4_q;
  logic [W-1:0] branch_target_q;

  alu_ctrl_decode u_dec (
    .alu_op_i   (bus.alu_op),
    .funct_i    (bus.funct),
    .alu_ctrl_o (alu_ctrl_d)
  );

  // Shifts operate on op_b by shamt; op_a does not participate.
  always_comb begin
    alu_result_d = '0;
    case (alu_ctrl_d)
      ALU_CTRL_AND:  alu_result_d = bus.op_a & bus.op_b;
      ALU_CTRL_OR:   alu_result_d = bus.op_a | bus.op_b;
      ALU_CTRL_ADD:  alu_result_d = bus.op_a + bus.op_b;
      ALU_CTRL_SUB:  alu_result_d = bus.op_a - bus.op_b;
      ALU_CTRL_XOR:  alu_result_d = bus.op_a ^ bus.op_b;
      ALU_CTRL_NOR:  alu_result_d = ~(bus.op_a | bus.op_b);
      ALU_CTRL_SLT:  alu_result_d = W'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_CTRL_SLTU: alu_result_d = W'(bus.op_a < bus.op_b);
      ALU_CTRL_SLL:  alu_result_d = bus.op_b << bus.shamt;
      ALU_CTRL_SRL:  alu_result_d = bus.op_b >> bus.shamt;
      ALU_CTRL_SRA:  alu_result_d = W'($signed(bus.op_b) >>> bus.shamt);
      ALU_CTRL_LUI:  alu_result_d = W'(bus.op_b[15:0]) << 16;
      default:       alu_result_d = '0;
    endcase
  end

  // Flag taken from the unregistered result so it lines up with alu_result_q.
  assign alu_zero_d      = (alu_result_d == '0);
  assign pc_plus4_d      = bus.pc + W'(PC_STEP);
  assign branch_target_d = pc_plus4_d + (bus.imm_ext << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      alu_ctrl_q      <= '0;
      alu_result_q    <= '0;
      alu_zero_q      <= 1'b0;  // cleared, not set, even though result is 0
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
    end else begin
      out_valid_q     <= bus.in_valid;
      alu_ctrl_q      <= alu_ctrl_d;
      alu_result_q    <= alu_result_d;
      alu_zero_q      <= alu_zero_d;
      pc_plus4_q      <= pc_plus4_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.alu_ctrl      = alu_ctrl_q;
  assign bus.alu_result    = alu_result_q;
  assign bus.alu_zero      = alu_zero_q;
  assign bus.pc_plus4      = pc_plus4_q;
  assign bus.branch_target = branch_target_q;

endmodule

// File: tb/tb_exec_alu_unit.sv
module tb_exec_alu_unit;

  typedef struct {
    string       tag;
    logic        vld;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zero;
    logic [31:0] pc4;
    logic [31:0] bt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];

  exec_alu_unit_if #(.W(32)) bus ();

  exec_alu_unit #(.W(32), .PC_STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation and push the values it must produce one cycle later.
  task automatic apply(input string tag, input logic vld, input logic [2:0] op,
                       input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [3:0] e_ctrl, input logic [31:0] e_res);
    exp_t e;
    bus.in_valid = vld;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.shamt    = sh;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.pc       = pc;
    bus.imm_ext  = imm;
    e.tag  = tag;
    e.vld  = vld;
    e.ctrl = e_ctrl;
    e.res  = e_res;
    e.zero = (e_res == 32'h0);
    e.pc4  = pc + 32'd4;
    e.bt   = pc + 32'd4 + (imm << 2);
    sb.push_back(e);
  endtask

  // Clock one edge, then pop the oldest expectation and compare every output.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".vld"},  {31'h0, bus.out_valid}, {31'h0, e.vld});
      chk({e.tag, ".ctrl"}, {28'h0, bus.alu_ctrl},  {28'h0, e.ctrl});
      chk({e.tag, ".res"},  bus.alu_result,         e.res);
      chk({e.tag, ".zero"}, {31'h0, bus.alu_zero},  {31'h0, e.zero});
      chk({e.tag, ".pc4"},  bus.pc_plus4,           e.pc4);
      chk({e.tag, ".bt"},   bus.branch_target,      e.bt);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vld"},  {31'h0, bus.out_valid}, 32'h0);
    chk({tag, ".ctrl"}, {28'h0, bus.alu_ctrl},  32'h0);
    chk({tag, ".res"},  bus.alu_result,         32'h0);
    chk({tag, ".zero"}, {31'h0, bus.alu_zero},  32'h0);
    chk({tag, ".pc4"},  bus.pc_plus4,           32'h0);
    chk({tag, ".bt"},   bus.branch_target,      32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    apply("init", 1'b0, 3'b000, 6'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h2, 32'h0);
    void'(sb.pop_back());
    #2;
    chk_all_zero("reset_init");

    @(negedge clk);
    rst_n = 1'b1;

    // Directed operations, back to back
    apply("radd", 1, 3'b010, 6'b100000, 5'd0, 32'd7, 32'd5, 32'h0, 32'h0, 4'b0010, 32'd12);
    step();
    apply("beq", 1, 3'b001, 6'h00, 5'd0, 32'h1234, 32'h1234, 32'h100, 32'hFFFF_FFFE, 4'b0110, 32'h0);
    step();
    apply("slt", 1, 3'b010, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 4'b0111, 32'd1);
    step();
    apply("sltu", 1, 3'b010, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 4'b1000, 32'd0);
    step();
    apply("srl", 1, 3'b010, 6'b000010, 5'd4, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 4'b0100, 32'h0800_0000);
    step();
    apply("sra", 1, 3'b010, 6'b000011, 5'd4, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h0, 4'b1001, 32'hF800_0000);
    step();
    apply("sll", 1, 3'b010, 6'b000000, 5'd4, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 4'b0011, 32'h0);
    step();
    apply("funct_unk", 1, 3'b010, 6'b111111, 5'd0, 32'd3, 32'd4, 32'hFFFF_FFFC, 32'h0, 4'b0010, 32'd7);
    step();
    apply("op111", 1, 3'b111, 6'b100010, 5'd0, 32'd3, 32'd4, 32'hFFFF_FFFC, 32'h1, 4'b0010, 32'd7);
    step();
    apply("and", 1, 3'b011, 6'h00, 5'd0, 32'hF0F0, 32'hFF00, 32'h40, 32'h10, 4'b0000, 32'hF000);
    step();
    apply("or", 1, 3'b100, 6'h00, 5'd0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 4'b0001, 32'hFFF0);
    step();
    apply("xor", 1, 3'b010, 6'b100110, 5'd0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 4'b0101, 32'h0FF0);
    step();
    apply("nor", 1, 3'b010, 6'b100111, 5'd0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 4'b1100, 32'hFFFF_000F);
    step();
    apply("lui", 1, 3'b110, 6'h00, 5'd0, 32'h5555, 32'h0001_ABCD, 32'h0, 32'h0, 4'b1010, 32'hABCD_0000);
    step();
    apply("add_wrap", 1, 3'b000, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 4'b0010, 32'h0);
    step();
    apply("slt_op", 1, 3'b101, 6'h00, 5'd0, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 4'b0111, 32'd1);
    step();
    apply("subu", 1, 3'b010, 6'b100011, 5'd0, 32'd5, 32'd7, 32'h0, 32'h0, 4'b0110, 32'hFFFF_FFFE);
    step();
    apply("novalid", 0, 3'b000, 6'h00, 5'd0, 32'd1, 32'd1, 32'h200, 32'h0, 4'b0010, 32'd2);
    step();

    // Reset mid-cycle clears outputs at once, with no clock edge
    apply("pre_rst", 1, 3'b000, 6'h00, 5'd0, 32'd9, 32'd9, 32'h300, 32'h4, 4'b0010, 32'd18);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_async");

    // In-flight operation dropped while reset is held across an edge
    apply("drop", 1, 3'b000, 6'h00, 5'd0, 32'd1, 32'd2, 32'h500, 32'h0, 4'b0010, 32'd3);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    chk_all_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    apply("post_rst", 1, 3'b010, 6'b100000, 5'd0, 32'd20, 32'd22, 32'h8, 32'h2, 4'b0010, 32'd42);
    step();

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
